// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - PS/2 mouse receiver: deglitched bit FSM, 3-byte packet decode, saturating cursor
module ps2_mouse_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int X_MAX          = 239,
   parameter int Y_MAX          = 319
) (
   input  logic       clock,
   input  logic       globalReset,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic       packetValid,
   output logic [2:0] buttons,
   output logic [8:0] xMove,
   output logic [8:0] yMove,
   output logic [7:0] cursorX,
   output logic [8:0] cursorY,
   output logic       frameError
);

   localparam int FW   = $clog2(FILTER_LEN + 1);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic signed [10:0] X_LIM = 11'(X_MAX);
   localparam logic signed [10:0] Y_LIM = 11'(Y_MAX);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          state, state_n;
   logic            ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
   logic            filt_c;
   logic [FW-1:0]   filt_cnt;
   logic            fall_evt;
   logic [TW-1:0]   to_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            perr;
   logic [1:0]      byte_idx;
   logic [3:0]      hdr_hi;
   logic [2:0]      hdr_btn;
   logic [7:0]      byte1;

   logic            start_ok, shift_en, par_chk, byte_ok, err, timeout;
   logic            ovf;
   logic [8:0]      x_new, y_new;
   logic signed [10:0] cx_sum, cy_sum;
   logic [7:0]      cx_next;
   logic [8:0]      cy_next;

   always_ff @(posedge clock or negedge globalReset) begin
      if (!globalReset) begin
         ps2c_s1 <= 1'b1;
         ps2c_s2 <= 1'b1;
         ps2d_s1 <= 1'b1;
         ps2d_s2 <= 1'b1;
      end else begin
         ps2c_s1 <= ps2c;
         ps2c_s2 <= ps2c_s1;
         ps2d_s1 <= ps2d;
         ps2d_s2 <= ps2d_s1;
      end
   end

   // filt_cnt counts consecutive samples that disagree with the filtered level
   assign fall_evt = filt_c && !ps2c_s2 && (filt_cnt == FILT_LAST);

   always_ff @(posedge clock or negedge globalReset) begin
      if (!globalReset) begin
         filt_c   <= 1'b1;
         filt_cnt <= '0;
      end else if (ps2c_s2 == filt_c) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
         filt_c   <= ps2c_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge globalReset) begin
      if (!globalReset) state <= S_IDLE;
      else              state <= state_n;
   end

   always_comb begin
      state_n  = state;
      start_ok = 1'b0;
      shift_en = 1'b0;
      par_chk  = 1'b0;
      byte_ok  = 1'b0;
      err      = 1'b0;
      timeout  = (state != S_IDLE) && !fall_evt && (to_cnt == TO_LAST);
      if (timeout) begin
         state_n = S_IDLE;
         err     = 1'b1;
      end else if (fall_evt) begin
         case (state)
            S_IDLE: begin
               if (!ps2d_s2) begin
                  state_n  = S_DATA;
                  start_ok = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
            S_DATA: begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_n = S_PARITY;
            end
            S_PARITY: begin
               par_chk = 1'b1;
               state_n = S_STOP;
            end
            S_STOP: begin
               state_n = S_IDLE;
               if (ps2d_s2 && !perr) byte_ok = 1'b1;
               else                  err     = 1'b1;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Packet decode uses the byte completing right now (shift) as Y low
   always_comb begin
      ovf     = hdr_hi[3] | hdr_hi[2];
      x_new   = ovf ? 9'd0 : {hdr_hi[0], byte1};
      y_new   = ovf ? 9'd0 : {hdr_hi[1], shift};
      cx_sum  = signed'({3'b000, cursorX}) + signed'({{2{x_new[8]}}, x_new});
      cy_sum  = signed'({2'b00, cursorY})  - signed'({{2{y_new[8]}}, y_new});
      cx_next = cx_sum[10] ? 8'd0 : (cx_sum > X_LIM) ? X_LIM[7:0] : cx_sum[7:0];
      cy_next = cy_sum[10] ? 9'd0 : (cy_sum > Y_LIM) ? Y_LIM[8:0] : cy_sum[8:0];
   end

   always_ff @(posedge clock or negedge globalReset) begin
      if (!globalReset) begin
         to_cnt      <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         perr        <= 1'b0;
         byte_idx    <= '0;
         hdr_hi      <= '0;
         hdr_btn     <= '0;
         byte1       <= '0;
         packetValid <= 1'b0;
         frameError  <= 1'b0;
         buttons     <= '0;
         xMove       <= '0;
         yMove       <= '0;
         cursorX     <= 8'(X_MAX / 2);
         cursorY     <= 9'(Y_MAX / 2);
      end else begin
         packetValid <= 1'b0;
         frameError  <= err;

         if (fall_evt || timeout || state == S_IDLE) to_cnt <= '0;
         else                                        to_cnt <= to_cnt + 1'b1;

         if (start_ok) begin
            bit_cnt <= '0;
            perr    <= 1'b0;
         end
         if (shift_en) begin
            shift   <= {ps2d_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (par_chk) perr <= ~^{shift, ps2d_s2};

         if (err) byte_idx <= '0;

         if (byte_ok) begin
            case (byte_idx)
               2'd0: begin
                  // Header bit 3 is always set; anything else means we are out of sync
                  if (shift[3]) begin
                     hdr_hi   <= shift[7:4];
                     hdr_btn  <= shift[2:0];
                     byte_idx <= 2'd1;
                  end
               end
               2'd1: begin
                  byte1    <= shift;
                  byte_idx <= 2'd2;
               end
               2'd2: begin
                  buttons     <= hdr_btn;
                  xMove       <= x_new;
                  yMove       <= y_new;
                  cursorX     <= cx_next;
                  cursorY     <= cy_next;
                  packetValid <= 1'b1;
                  byte_idx    <= 2'd0;
               end
               default: byte_idx <= 2'd0;
            endcase
         end
      end
   end

endmodule
